// File: rtl/ex.sv
// Execute stage: logic/shift/arith ops with a combinational result path, plus an
// optional iterative unsigned divider (define EX_DIV_EN) that writes HI/LO and stalls.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stall_req_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  logic signed [31:0] op1_s;
  logic signed [31:0] op2_s;
  logic        [31:0] logic_res;
  logic        [31:0] shift_res;
  logic        [31:0] arith_res;
  logic               is_divu;

  assign op1_s   = reg1_i;
  assign op2_s   = reg2_i;
  assign is_divu = (aluop_i == EXE_DIVU_OP);

  always_comb begin
    logic_res = 32'h0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = 32'h0;
    endcase
  end

  always_comb begin
    shift_res = 32'h0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = op2_s >>> reg1_i[4:0];
      default:    shift_res = 32'h0;
    endcase
  end

  always_comb begin
    arith_res = 32'h0;
    case (aluop_i)
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'h0, (op1_s < op2_s)};
      EXE_SLTU_OP: arith_res = {31'h0, (reg1_i < reg2_i)};
      default:     arith_res = 32'h0;
    endcase
  end

  always_comb begin
    wd_o    = 5'h0;
    wreg_o  = 1'b0;
    wdata_o = 32'h0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i && (alusel_i != EXE_RES_NOP) && !is_divu;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        EXE_RES_ARITH: wdata_o = arith_res;
        default:       wdata_o = 32'h0;
      endcase
    end
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE, DIV_ON, DIV_END} div_state_t;

  div_state_t  state;
  div_state_t  state_nxt;
  logic [5:0]  cnt;
  logic [31:0] div_rem;
  logic [31:0] div_quot;
  logic [31:0] div_dvsr;
  logic        stall_nxt;
  logic        whilo_nxt;

  // One restoring step: shift {rem,quot} left, keep the trial difference if it did not borrow.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quot,
                                           input logic [31:0] dvsr);
    logic [32:0] shifted;
    logic [32:0] trial;
    shifted = {rem, quot[31]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[32]) div_step = {trial[31:0], quot[30:0], 1'b1};
    else            div_step = {shifted[31:0], quot[30:0], 1'b0};
  endfunction

  always_comb begin
    state_nxt = state;
    stall_nxt = 1'b0;
    whilo_nxt = 1'b0;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_divu) begin
            stall_nxt = 1'b1;
            state_nxt = (reg2_i == 32'h0) ? DIV_END : DIV_ON;
          end
        end
        DIV_ON: begin
          stall_nxt = 1'b1;
          if (cnt == 6'd31) state_nxt = DIV_END;
        end
        DIV_END: begin
          whilo_nxt = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req_o = 1'b0;
    whilo_o     = 1'b0;
    hi_o        = 32'h0;
    lo_o        = 32'h0;
    if (!rst) begin
      stall_req_o = stall_nxt;
      whilo_o     = whilo_nxt;
      if (whilo_nxt) begin
        hi_o = div_rem;
        lo_o = div_quot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      if (state == DIV_ON) cnt <= cnt + 6'd1;
      else                 cnt <= 6'd0;
    end
  end

  // Operand latch and iteration datapath; the quotient register starts out holding the dividend.
  always_ff @(posedge clk) begin
    if (state == IDLE && is_divu) begin
      div_dvsr <= reg2_i;
      if (reg2_i == 32'h0) begin
        div_rem  <= reg1_i;
        div_quot <= 32'hFFFF_FFFF;
      end else begin
        div_rem  <= 32'h0;
        div_quot <= reg1_i;
      end
    end else if (state == DIV_ON) begin
      {div_rem, div_quot} <= div_step(div_rem, div_quot, div_dvsr);
    end
  end
`else
  logic unused_nodiv;
  assign unused_nodiv = &{1'b0, clk, flush_i};
  assign stall_req_o  = 1'b0;
  assign whilo_o      = 1'b0;
  assign hi_o         = 32'h0;
  assign lo_o         = 32'h0;
`endif

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS32 pipeline. It consumes the decoded operation bundle produced by the decode stage (`aluop`, `alusel`, two 32-bit operands, destination address, write enable) and produces the write-back bundle for the EX/MEM register. Single-cycle logic, shift and arithmetic ops resolve combinationally. An optional iterative unsigned divider writes HI/LO and stalls the pipeline while it runs.

## Interface
Parameters:
- none; widths come from the shared defines (`AluOpBus` = 8 bits, `AluSelBus` = 3 bits, `RegBus` = 32 bits, `RegAddrBus` = 5 bits).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1)
- `aluop_i`  in  8  operation code (`EXE_*_OP`)
- `alusel_i`  in  3  result class (`EXE_RES_LOGIC`, `EXE_RES_SHIFT`, `EXE_RES_ARITH`, `EXE_RES_NOP`)
- `reg1_i`  in  32  operand 1 (rs, or shift amount source)
- `reg2_i`  in  32  operand 2 (rt or immediate)
- `wd_i`  in  5  destination register address
- `wreg_i`  in  1  destination write enable
- `flush_i`  in  1  abort in-flight divide
- `wd_o`  out  5  destination address, passed through
- `wreg_o`  out  1  write enable to GPR
- `wdata_o`  out  32  GPR write data
- `hi_o`, `lo_o`  out  32 each  HI/LO write data
- `whilo_o`  out  1  HI/LO write enable
- `stall_req_o`  out  1  hold request to pipeline control

## Operation
- While `rst` high: all outputs 0. Divider FSM returns to IDLE at the next edge.
- `wd_o = wd_i`; `wreg_o = wreg_i`, except it is forced to 0 for `EXE_RES_NOP` and DIVU.
- Logic ops: OR, AND, XOR, NOR on `reg1_i` and `reg2_i`.
- Shifts: SLL, SRL, SRA of `reg2_i` by `reg1_i[4:0]`. SRA sign-fills.
- Arithmetic:
  - ADDU, SUBU wrap modulo 2^32; no overflow trap.
  - SLT is a signed compare, SLTU unsigned; result is 32'h1 or 32'h0.
- `wdata_o` is selected by `alusel_i`; unknown `alusel_i` gives 0.
- Unknown `aluop_i` within a valid class gives `wdata_o` = 0.
- DIVU FSM, states IDLE, DIV_ON, DIV_END:
  - IDLE + DIVU, divisor ≠ 0: latch operands, clear 6-bit counter, go to DIV_ON, `stall_req_o` = 1.
  - IDLE + DIVU, divisor = 0: go directly to DIV_END with quotient 32'hFFFFFFFF and remainder = dividend; `stall_req_o` = 1.
  - DIV_ON: one restoring-division step per cycle (shift partial remainder left, trial-subtract divisor, set quotient bit); `stall_req_o` = 1. After the 32nd step, go to DIV_END.
  - DIV_END (one cycle): `lo_o` = quotient, `hi_o` = remainder, `whilo_o` = 1, `stall_req_o` = 0. Then go to IDLE unconditionally; the pipeline advances, so DIVU is not re-issued.
- `flush_i` high in any state: next state IDLE, and in that cycle `stall_req_o` = 0 and `whilo_o` = 0. `flush_i` has priority over DIVU start.
- Operand changes during DIV_ON are ignored; the latched copies are used.

## Timing
- Non-divide ops: zero-cycle latency (combinational); `stall_req_o` = 0.
- DIVU issued in cycle N (state IDLE):
  - `stall_req_o` = 1 for cycles N..N+32.
  - Result with `whilo_o` = 1 in cycle N+33.
- Divide by zero: stall in cycle N only; result in N+1.
- `rst` asserted mid-divide: outputs 0 that cycle, IDLE next cycle, no HI/LO write.
- Simultaneous `rst` and `flush_i`: reset wins.

## Configuration
- `EX_DIV_EN` defined: divider FSM and HI/LO outputs behave as above.
- `EX_DIV_EN` undefined:
  - Divider logic is not built.
  - DIVU behaves as NOP: `wreg_o` = 0, `whilo_o` = 0.
  - `stall_req_o`, `hi_o`, `lo_o`, `whilo_o` are tied to 0.

## Test plan
- ORI-style OR, `reg1_i`=32'h0000_1100, `reg2_i`=32'h0000_0011, `wreg_i`=1, `wd_i`=5 -> same cycle `wdata_o`=32'h0000_1111, `wreg_o`=1, `wd_o`=5.
- SRA, `reg2_i`=32'h8000_0000, `reg1_i`=32'h0000_0024 (amount 4) -> `wdata_o`=32'hF800_0000. SLT with reg1=32'hFFFF_FFFF, reg2=1 -> 1; SLTU with same operands -> 0.
- DIVU 100/7 at cycle N -> `stall_req_o` high N..N+32; at N+33 `lo_o`=14, `hi_o`=2, `whilo_o`=1, `wreg_o`=0; IDLE at N+34.
- DIVU 5/0 -> stall in N only; at N+1 `lo_o`=32'hFFFF_FFFF, `hi_o`=5, `whilo_o`=1.
- DIVU started, `flush_i` pulsed at N+10 -> `stall_req_o`=0 at N+10, no `whilo_o` pulse ever, IDLE at N+11; repeat the sequence with `rst` in place of `flush_i` -> all outputs 0 that cycle.
- Build with `EX_DIV_EN` undefined, issue DIVU 100/7 -> `stall_req_o`, `whilo_o`, `wreg_o` stay 0 throughout.
